// File: rtl/pwm_pkg.sv
// Shared constants and encodings for the multi-channel PWM block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int PWM_WIDTH          = 16;
    localparam int PWM_CHANNELS       = 4;
    localparam int PWM_DEFAULT_PERIOD = 4999;  // 10 kHz edge-aligned at 50 MHz

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: active compare window registers plus registered window compare.
// Latency: pwm follows cnt by 1 clock.
// Backpressure: none; strobes from the timebase are consumed unconditionally.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             xfer,
    input  logic             use_new,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] shadow_cr1,
    input  logic [WIDTH-1:0] shadow_cr2,
    output logic             pwm
);

    logic [WIDTH-1:0] cr1_q;
    logic [WIDTH-1:0] cr2_q;
    logic [WIDTH-1:0] cmp1;
    logic [WIDTH-1:0] cmp2;

    // On a period-start boundary with an update pending, the counter-0 sample
    // already belongs to the new period, so it is compared against the shadow.
    always_comb begin
        cmp1 = cr1_q;
        cmp2 = cr2_q;
        if (use_new) begin
            cmp1 = shadow_cr1;
            cmp2 = shadow_cr2;
        end
    end

    // Active window registers, replaced only at a period boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            cr1_q <= '0;
            cr2_q <= '0;
        end else if (xfer) begin
            cr1_q <= shadow_cr1;
            cr2_q <= shadow_cr2;
        end
    end

    // Registered window compare; output forced low while stopped.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (cnt >= cmp1) && (cnt < cmp2);
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/centre-aligned timebase with double-buffered period, mode and windows.
// Latency: pwm 1 clock after counter; cycle_start during the boundary cycle; update_done 1 clock after transfer.
// Backpressure: none; load is always accepted, last load before a boundary wins.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH          = PWM_WIDTH,
    parameter int CHANNELS       = PWM_CHANNELS,
    parameter int DEFAULT_PERIOD = PWM_DEFAULT_PERIOD
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      center,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] cr1,
    input  logic [CHANNELS*WIDTH-1:0] cr2,
    input  logic                      load,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      cycle_start,
    output logic                      update_done
);

    typedef struct packed {
        logic [WIDTH-1:0] period;
        mode_e            mode;
    } tbase_t;

    tbase_t                    act_q;
    tbase_t                    shd_q;
    tbase_t                    eff;
    logic [CHANNELS*WIDTH-1:0] shd_cr1_q;
    logic [CHANNELS*WIDTH-1:0] shd_cr2_q;
    logic                      pending_q;
    logic                      running_q;
    logic [WIDTH-1:0]          cnt_q;
    logic [WIDTH-1:0]          cnt_d;
    dir_e                      dir_q;
    dir_e                      dir_d;
    logic                      first;
    logic                      start_bnd;
    logic                      end_bnd;
    logic                      boundary;
    logic                      xfer;
    logic                      use_new;

    // Boundary decode. Start-type boundaries (first enabled cycle, centre-mode
    // bottom) sit on the counter-0 sample of the new period; the edge-mode
    // boundary sits on the last sample (cnt == P) of the old period.
    always_comb begin
        first     = enable && !running_q;
        start_bnd = enable && (first ||
                    (act_q.mode == MODE_CENTER && dir_q == DIR_DOWN && cnt_q == '0));
        end_bnd   = enable && running_q && act_q.mode == MODE_EDGE &&
                    cnt_q >= act_q.period;
        boundary  = start_bnd || end_bnd;
        xfer      = boundary && pending_q;
        use_new   = start_bnd && pending_q;
        eff       = use_new ? shd_q : act_q;
    end

    // Counter/direction next state; after a start-type boundary the next step
    // already follows the incoming period and mode.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!enable || end_bnd) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (start_bnd) begin
            if (eff.period == '0) begin
                cnt_d = '0;
                dir_d = (eff.mode == MODE_CENTER) ? DIR_DOWN : DIR_UP;
            end else begin
                cnt_d = WIDTH'(1);
                dir_d = DIR_UP;
            end
        end else if (act_q.mode == MODE_EDGE) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else if (dir_q == DIR_UP) begin
            if (cnt_q >= act_q.period) begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - WIDTH'(1);
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Counter/direction state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            dir_q <= DIR_UP;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    // Shadow capture, pending flag and shadow-to-active transfer. A load on a
    // boundary edge lands in the shadow after the old shadow was transferred.
    always_ff @(posedge clock) begin
        if (reset) begin
            act_q       <= '{period: WIDTH'(DEFAULT_PERIOD), mode: MODE_EDGE};
            shd_q       <= '{period: '0, mode: MODE_EDGE};
            shd_cr1_q   <= '0;
            shd_cr2_q   <= '0;
            pending_q   <= 1'b0;
            running_q   <= 1'b0;
            update_done <= 1'b0;
        end else begin
            running_q   <= enable;
            update_done <= xfer;
            pending_q   <= load || (pending_q && !xfer);
            if (xfer) begin
                act_q <= shd_q;
            end
            if (load) begin
                shd_q     <= '{period: period, mode: mode_e'(center)};
                shd_cr1_q <= cr1;
                shd_cr2_q <= cr2;
            end
        end
    end

    assign cycle_start = boundary && !reset;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .run        (enable),
            .xfer       (xfer),
            .use_new    (use_new),
            .cnt        (cnt_q),
            .shadow_cr1 (shd_cr1_q[i*WIDTH +: WIDTH]),
            .shadow_cr2 (shd_cr2_q[i*WIDTH +: WIDTH]),
            .pwm        (pwm[i])
        );
    end

endmodule
